vend2_change_hopper: RTL and testbench

//  Coin-return stage directly downstream of the vend2 controller. Consumes money_return/return_amount

---
 rtl/vend2_pkg.sv | 24 ++
 rtl/vend2_ret_fifo.sv | 54 +++++
 rtl/vend2_change_hopper.sv | 154 +++++++++++++++
 tb/tb_vend2_change_hopper.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend2_pkg.sv
// Shared types for the vend2 coin-return path: hopper indexing and hopper FSM states.
package vend2_pkg;

  localparam int unsigned NUM_HOPPERS = 16;
  localparam int unsigned COIN_IDX_W  = 4;

  typedef logic [COIN_IDX_W-1:0] coin_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    EJECT,
    WAIT_SENSE,
    DONE
  } hopper_state_e;

  // One-hot solenoid select for a hopper index
  function automatic logic [NUM_HOPPERS-1:0] idx_onehot(input coin_idx_t idx);
    logic [NUM_HOPPERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/vend2_ret_fifo.sv
// Synchronous request FIFO for pending coin returns; a push into a full queue is
// accepted only when a pop happens in the same cycle.
module vend2_ret_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_c = (cnt_q == '0);
  assign full_c  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_c;
  assign do_push = push_i && (!full_c || do_pop);
  assign rdata_c = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vend2_change_hopper.sv
// Coin-return stage: queues return requests, pulses one hopper solenoid per coin,
// confirms the drop via the chute sensor and tracks per-hopper counts and jams.
module vend2_change_hopper
  import vend2_pkg::*;
#(
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned INIT_COUNT    = 20,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned EJECT_CYCLES  = 3,
  parameter int unsigned SENSE_TIMEOUT = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   money_return,
  input  logic [COIN_IDX_W-1:0]  return_amount,
  output logic                   return_complete,
  output logic                   return_error,
  output logic [NUM_HOPPERS-1:0] hopper_empty,
  output logic [NUM_HOPPERS-1:0] coin_eject,
  input  logic                   coin_sensed,
  input  logic                   refill_valid,
  input  logic [COIN_IDX_W-1:0]  refill_index,
  input  logic [CNT_W-1:0]       refill_count,
  output logic                   fifo_overflow
);

  localparam int unsigned EJ_W = $clog2(EJECT_CYCLES + 1);
  localparam int unsigned TO_W = $clog2(SENSE_TIMEOUT + 1);
  localparam logic [NUM_HOPPERS-1:0] EMPTY_RST =
    (INIT_COUNT == 0) ? {NUM_HOPPERS{1'b1}} : {NUM_HOPPERS{1'b0}};

  hopper_state_e        state_q, state_d;
  coin_idx_t            idx_q, idx_d;
  logic                 err_q, err_d;
  logic [EJ_W-1:0]      ej_cnt_q, ej_cnt_d;
  logic [TO_W-1:0]      tmr_q, tmr_d;
  logic [CNT_W-1:0]     count_q [NUM_HOPPERS];
  logic [CNT_W-1:0]     count_d [NUM_HOPPERS];
  logic [NUM_HOPPERS-1:0] jam_q, jam_d, empty_d;
  logic                 pop_c, dec_c, jam_set_c, ovf_c;
  coin_idx_t            fifo_head_c;
  logic                 fifo_full_c, fifo_empty_c;

  vend2_ret_fifo #(
    .WIDTH (COIN_IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .push_i  (money_return),
    .wdata_i (return_amount),
    .pop_i   (pop_c),
    .rdata_c (fifo_head_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  assign ovf_c = money_return && fifo_full_c && !pop_c;

  // Request sequencing: pop, eject, wait for the drop sensor, report
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    ej_cnt_d  = ej_cnt_q;
    tmr_d     = tmr_q;
    pop_c     = 1'b0;
    dec_c     = 1'b0;
    jam_set_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_c) begin
          pop_c    = 1'b1;
          idx_d    = fifo_head_c;
          ej_cnt_d = '0;
          if (hopper_empty[fifo_head_c]) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = EJECT;
          end
        end
      end
      EJECT: begin
        if (ej_cnt_q == EJ_W'(EJECT_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = WAIT_SENSE;
        end else begin
          ej_cnt_d = ej_cnt_q + EJ_W'(1);
        end
      end
      WAIT_SENSE: begin
        if (coin_sensed) begin
          dec_c   = 1'b1;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (tmr_q == TO_W'(SENSE_TIMEOUT - 1)) begin
          jam_set_c = 1'b1;
          err_d     = 1'b1;
          state_d   = DONE;
        end else begin
          tmr_d = tmr_q + TO_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Hopper bookkeeping; a refill overrides a same-cycle decrement or jam
  always_comb begin
    for (int i = 0; i < NUM_HOPPERS; i++) count_d[i] = count_q[i];
    jam_d = jam_q;
    if (dec_c && (count_q[idx_q] != '0)) count_d[idx_q] = count_q[idx_q] - CNT_W'(1);
    if (jam_set_c) jam_d[idx_q] = 1'b1;
    if (refill_valid) begin
      count_d[refill_index] = refill_count;
      jam_d[refill_index]   = 1'b0;
    end
    for (int i = 0; i < NUM_HOPPERS; i++) empty_d[i] = (count_d[i] == '0) || jam_d[i];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      err_q           <= 1'b0;
      ej_cnt_q        <= '0;
      tmr_q           <= '0;
      jam_q           <= '0;
      for (int i = 0; i < NUM_HOPPERS; i++) count_q[i] <= CNT_W'(INIT_COUNT);
      hopper_empty    <= EMPTY_RST;
      coin_eject      <= '0;
      return_complete <= 1'b0;
      return_error    <= 1'b0;
      fifo_overflow   <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      err_q           <= err_d;
      ej_cnt_q        <= ej_cnt_d;
      tmr_q           <= tmr_d;
      jam_q           <= jam_d;
      for (int i = 0; i < NUM_HOPPERS; i++) count_q[i] <= count_d[i];
      hopper_empty    <= empty_d;
      coin_eject      <= (state_d == EJECT) ? idx_onehot(idx_d) : '0;
      return_complete <= (state_d == DONE);
      return_error    <= (state_d == DONE) && err_d;
      fifo_overflow   <= fifo_overflow || ovf_c;
    end
  end

endmodule

// File: tb/tb_vend2_change_hopper.sv
// Bench for vend2_change_hopper: a reactive chute model answers each eject, and a
// transaction-level hopper model predicts every completion's error flag.
module tb_vend2_change_hopper;

  localparam int unsigned CNT_W         = 8;
  localparam int unsigned INIT_COUNT    = 20;
  localparam int unsigned FIFO_DEPTH    = 4;
  localparam int unsigned EJECT_CYCLES  = 3;
  localparam int unsigned SENSE_TIMEOUT = 16;
  localparam int          NH            = 16;
  localparam int          NEVER         = 1000;
  localparam int          NV            = 8;

  typedef struct {
    int idx;
    int delay;
  } plan_t;

  typedef struct {
    bit do_refill;
    int ridx;
    int rval;
    int idx;
    int delay;
    bit exp_err;
    int lat_min;
    int lat_max;
  } vec_t;

  logic             clock;
  logic             reset;
  logic             money_return;
  logic [3:0]       return_amount;
  logic             return_complete;
  logic             return_error;
  logic [15:0]      hopper_empty;
  logic [15:0]      coin_eject;
  logic             coin_sensed;
  logic             refill_valid;
  logic [3:0]       refill_index;
  logic [CNT_W-1:0] refill_count;
  logic             fifo_overflow;

  int    checks = 0;
  int    errors = 0;
  int    nissued = 0;
  int    ncomplete = 0;
  bit    chute_en = 1'b0;
  int    mcount [NH];
  bit    mjam [NH];
  plan_t plan_q [$];
  bit    exp_err_q [$];
  vec_t  vecs [NV];

  vend2_change_hopper #(
    .CNT_W         (CNT_W),
    .INIT_COUNT    (INIT_COUNT),
    .FIFO_DEPTH    (FIFO_DEPTH),
    .EJECT_CYCLES  (EJECT_CYCLES),
    .SENSE_TIMEOUT (SENSE_TIMEOUT)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .money_return    (money_return),
    .return_amount   (return_amount),
    .return_complete (return_complete),
    .return_error    (return_error),
    .hopper_empty    (hopper_empty),
    .coin_eject      (coin_eject),
    .coin_sensed     (coin_sensed),
    .refill_valid    (refill_valid),
    .refill_index    (refill_index),
    .refill_count    (refill_count),
    .fifo_overflow   (fifo_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_empty();
    logic [15:0] v;
    for (int i = 0; i < NH; i++) v[i] = (mcount[i] == 0) || mjam[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NH; i++) begin
      mcount[i] = INIT_COUNT;
      mjam[i]   = 1'b0;
    end
  endtask

  // Predict one request in arrival order; delay is when the chute will drop the coin
  task automatic model_req(input int idx, input int delay);
    if (mcount[idx] == 0 || mjam[idx]) begin
      exp_err_q.push_back(1'b1);
    end else begin
      plan_q.push_back('{idx, delay});
      if (delay < SENSE_TIMEOUT) begin
        mcount[idx] = mcount[idx] - 1;
        exp_err_q.push_back(1'b0);
      end else begin
        mjam[idx] = 1'b1;
        exp_err_q.push_back(1'b1);
      end
    end
  endtask

  task automatic issue(input int idx, input int delay);
    model_req(idx, delay);
    nissued++;
    money_return  = 1'b1;
    return_amount = 4'(idx);
    @(negedge clock);
    money_return  = 1'b0;
  endtask

  task automatic do_refill(input int idx, input int val);
    refill_valid = 1'b1;
    refill_index = 4'(idx);
    refill_count = CNT_W'(val);
    @(negedge clock);
    refill_valid = 1'b0;
    mcount[idx]  = val;
    mjam[idx]    = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (ncomplete != nissued && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("drain_completions", 32'(ncomplete), 32'(nissued));
  endtask

  // Chute: consumes the planned coin for each eject and pulses the sensor after its delay
  initial begin : chute
    plan_t p;
    int    len;
    forever begin
      @(negedge clock);
      if (chute_en && coin_eject != '0) begin
        if (plan_q.size() == 0) begin
          chk("unexpected_eject", 32'(coin_eject), 32'd0);
        end else begin
          p = plan_q.pop_front();
          chk("eject_onehot", 32'(coin_eject), 32'(1) << p.idx);
          len = 1;
          while (len < 40) begin
            @(negedge clock);
            if (coin_eject == '0) break;
            len++;
          end
          chk("eject_len", 32'(len), 32'(EJECT_CYCLES));
          if (p.delay != NEVER) begin
            repeat (p.delay) @(negedge clock);
            coin_sensed = 1'b1;
            @(negedge clock);
            coin_sensed = 1'b0;
          end
        end
      end
    end
  end

  // Completion monitor: each pulse must match the next predicted error flag
  initial begin : mon
    forever begin
      @(negedge clock);
      if (return_complete) begin
        if (exp_err_q.size() == 0) chk("unexpected_complete", 32'd1, 32'd0);
        else chk("return_error", 32'(return_error), 32'(exp_err_q.pop_front()));
        ncomplete++;
      end
    end
  end

  initial begin : main
    int lat;
    int n;
    int r;
    int d;
    vecs[0] = '{1'b0, 0, 0,  3, 1,     1'b0, 7,  7};
    vecs[1] = '{1'b1, 7, 1,  7, 0,     1'b0, 6,  6};
    vecs[2] = '{1'b0, 0, 0,  7, 0,     1'b1, 2,  3};
    vecs[3] = '{1'b0, 0, 0,  9, NEVER, 1'b1, 21, 21};
    vecs[4] = '{1'b1, 9, 5,  9, 15,    1'b0, 21, 21};
    vecs[5] = '{1'b0, 0, 0,  5, 16,    1'b1, 21, 21};
    vecs[6] = '{1'b1, 5, 0,  5, 0,     1'b1, 2,  3};
    vecs[7] = '{1'b0, 0, 0, 15, 4,     1'b0, 10, 10};

    reset = 1'b0; money_return = 1'b0; return_amount = '0; coin_sensed = 1'b0;
    refill_valid = 1'b0; refill_index = '0; refill_count = '0;
    model_reset();
    repeat (3) @(negedge clock);
    chk("rst_complete", 32'(return_complete), 32'd0);
    chk("rst_error", 32'(return_error), 32'd0);
    chk("rst_eject", 32'(coin_eject), 32'd0);
    chk("rst_empty", 32'(hopper_empty), 32'd0);
    chk("rst_overflow", 32'(fifo_overflow), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    chute_en = 1'b1;

    // Table of single requests: normal, empty, jam, timeout boundaries
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].do_refill) do_refill(vecs[i].ridx, vecs[i].rval);
      issue(vecs[i].idx, vecs[i].delay);
      lat = 1;
      while (!return_complete && lat < 60) begin
        @(negedge clock);
        lat++;
      end
      chk($sformatf("vec%0d_complete", i), 32'(return_complete), 32'd1);
      chk($sformatf("vec%0d_error", i), 32'(return_error), 32'(vecs[i].exp_err));
      checks++;
      if (lat < vecs[i].lat_min || lat > vecs[i].lat_max) begin
        errors++;
        $display("FAIL vec%0d_latency actual=%0d expected=%0d..%0d", i, lat,
                 vecs[i].lat_min, vecs[i].lat_max);
      end
      @(negedge clock);
      @(negedge clock);
      chk($sformatf("vec%0d_empty", i), 32'(hopper_empty), 32'(model_empty()));
      chk($sformatf("vec%0d_count", i), 32'(dut.count_q[vecs[i].idx]), 32'(mcount[vecs[i].idx]));
    end
    drain();

    // Burst: fill the queue behind an in-flight coin, drop one, then push-while-popping when full
    issue(0, 0); issue(1, 0); issue(2, 0); issue(3, 0); issue(4, 0);
    chk("burst_ovf_before", 32'(fifo_overflow), 32'd0);
    money_return = 1'b1; return_amount = 4'd8;
    @(negedge clock);
    money_return = 1'b0;
    chk("burst_ovf_after", 32'(fifo_overflow), 32'd1);
    @(negedge clock);
    issue(6, 0);
    drain();
    repeat (30) @(negedge clock);
    chk("burst_total", 32'(ncomplete), 32'(nissued));
    chk("burst_dropped_count", 32'(dut.count_q[8]), 32'(mcount[8]));
    chk("burst_pushpop_count", 32'(dut.count_q[6]), 32'(mcount[6]));
    chk("burst_empty", 32'(hopper_empty), 32'(model_empty()));

    // Refill and coin drop on the same hopper in the same cycle
    chute_en = 1'b0;
    exp_err_q.push_back(1'b0);
    nissued++;
    money_return = 1'b1; return_amount = 4'd2;
    @(negedge clock);
    money_return = 1'b0;
    n = 0;
    while (!coin_eject[2] && n < 20) begin @(negedge clock); n++; end
    while (coin_eject != '0 && n < 40) begin @(negedge clock); n++; end
    chk("collide_eject_seen", 32'(n < 40 && n > 0), 32'd1);
    coin_sensed = 1'b1; refill_valid = 1'b1; refill_index = 4'd2; refill_count = CNT_W'(10);
    @(negedge clock);
    coin_sensed = 1'b0; refill_valid = 1'b0;
    mcount[2] = 10; mjam[2] = 1'b0;
    drain();
    chk("collide_count", 32'(dut.count_q[2]), 32'd10);
    chk("collide_empty", 32'(hopper_empty), 32'(model_empty()));
    chute_en = 1'b1;

    // Randomised traffic against the model, with occasional refills while idle
    for (int it = 0; it < 300; it++) begin
      if ((it % 75) == 74) begin
        drain();
        do_refill(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        @(negedge clock);
        chk("rand_refill_empty", 32'(hopper_empty), 32'(model_empty()));
      end else if ((nissued - ncomplete) < int'(FIFO_DEPTH) && $urandom_range(0, 99) < 35) begin
        r = int'($urandom_range(0, 99));
        if (r < 70)      d = int'($urandom_range(0, 15));
        else if (r < 85) d = 16;
        else             d = NEVER;
        issue(int'($urandom_range(0, 15)), d);
      end else begin
        @(negedge clock);
      end
    end
    drain();
    @(negedge clock);
    chk("rand_final_empty", 32'(hopper_empty), 32'(model_empty()));
    chk("rand_plans_used", 32'(plan_q.size()), 32'd0);

    // Reset while a coin is being ejected with another request queued
    chute_en = 1'b0;
    money_return = 1'b1; return_amount = 4'd1;
    @(negedge clock);
    return_amount = 4'd4;
    @(negedge clock);
    money_return = 1'b0;
    n = 0;
    while (coin_eject == '0 && n < 20) begin @(negedge clock); n++; end
    chk("midrst_eject_active", 32'(coin_eject), 32'h2);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("midrst_eject_off", 32'(coin_eject), 32'd0);
    chk("midrst_fifo_empty", 32'(dut.u_fifo.empty_c), 32'd1);
    chk("midrst_count", 32'(dut.count_q[1]), 32'(INIT_COUNT));
    chk("midrst_empty", 32'(hopper_empty), 32'd0);
    chk("midrst_overflow", 32'(fifo_overflow), 32'd0);
    n = 0;
    repeat (40) begin
      @(negedge clock);
      if (return_complete || coin_eject != '0) n++;
    end
    chk("midrst_quiet", 32'(n), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
